// File: rtl/multicycle_control_pkg.sv
// Shared opcodes, control encodings and FSM states for the multicycle control unit.
// ADDI_SUPPORT_EN adds the ADDI execute/writeback states.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JUMP
`ifdef ADDI_SUPPORT_EN
    , S_ADDIEX
    , S_ADDIWB
`endif
  } ctrl_state_t;

endpackage

// File: rtl/multicycle_control_wait.sv
// Memory wait counter: counts stalled cycles and flags expiry.
// MEM_TIMEOUT of 0 disables expiry entirely.
module control_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST =
    (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = count && (MEM_TIMEOUT != 0) && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire) cnt_d = '0;
    else if (count)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle control FSM with memory-ready stalls and wait timeout.
// Define ADDI_SUPPORT_EN to decode ADDI.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       illegalOp,
  output logic       memTimeout
);

  ctrl_state_t state_q, state_d;
  logic        wait_st, wait_cnt, expire;

  assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEMRD)
                 || (state_q == S_MEMWR);
  assign wait_cnt = wait_st && !memReady && !rst;

  control_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (!wait_cnt),
    .count (wait_cnt),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = PCSRC_ALU;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = ALUSRCB_B;
    aluOp       = ALUOP_ADD;
    illegalOp   = 1'b0;
    memTimeout  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = ALUSRCB_FOUR;
          irWrite = memReady;
          pcWrite = memReady;
          if (memReady) state_d = S_DECODE;
        end
        S_DECODE: begin
          aluSrcB = ALUSRCB_IMMSH;
          unique case (opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
`ifdef ADDI_SUPPORT_EN
            OP_ADDI:      state_d = S_ADDIEX;
`endif
            default: begin
              illegalOp = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = ALUSRCB_IMM;
          state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          memRead = 1'b1;
          iorD    = 1'b1;
          if (memReady) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          memWrite = 1'b1;
          iorD     = 1'b1;
          if (memReady) state_d = S_FETCH;
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          aluOp   = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          regWrite = 1'b1;
          regDst   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          aluSrcA     = 1'b1;
          aluOp       = ALUOP_SUB;
          pcWriteCond = 1'b1;
          pcSource    = PCSRC_ALUOUT;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          pcWrite  = 1'b1;
          pcSource = PCSRC_JUMP;
          state_d  = S_FETCH;
        end
`ifdef ADDI_SUPPORT_EN
        S_ADDIEX: begin
          aluSrcA = 1'b1;
          aluSrcB = ALUSRCB_IMM;
          state_d = S_ADDIWB;
        end
        S_ADDIWB: begin
          regWrite = 1'b1;
          state_d  = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
      // An expired wait abandons the access: no request or enable this cycle.
      if (expire) begin
        memTimeout = 1'b1;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        state_d    = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule
